servo_command_exec: RTL



---
 rtl/servo_cmd_pkg.sv | 25 ++
 rtl/servo_pwm_channel.sv | 31 +++
 rtl/servo_command_exec.sv | 136 +++++++++++++
 3 files changed

// File: rtl/servo_cmd_pkg.sv
// servo_cmd_pkg: shared constants, instruction field positions, FSM states and the saturating step helper
package servo_cmd_pkg;
  localparam int INSTR_W = 11;
  localparam int POS_W = 7;
  localparam int MAX_SERVOS = 4;
  localparam logic [POS_W-1:0] POS_CENTER = 7'd64;
  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_MASK = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;
  localparam int OP_HI = 10;
  localparam int OP_LO = 9;
  localparam int ID_HI = 8;
  localparam int ID_LO = 7;
  localparam int VAL_HI = 6;
  localparam int VAL_LO = 0;
  typedef enum logic {IDLE, EXEC} state_e;
  // val[6] is the sign (1 = decrement), val[5:0] the magnitude; result clamps to 0..127
  function automatic logic [POS_W-1:0] sat_step(input logic [POS_W-1:0] cur, input logic [POS_W-1:0] val);
    logic [POS_W:0] sum;
    sum = {1'b0, cur} + {2'b00, val[5:0]};
    return val[6] ? ((cur > {1'b0, val[5:0]}) ? cur - {1'b0, val[5:0]} : '0)
                  : (sum[POS_W] ? '1 : sum[POS_W-1:0]);
  endfunction
endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one PWM output with shadow position/enable reloaded at each frame start
// Ports: clk, rst_n (sync, active low); load_i frame-start strobe; pos_i/en_i live settings;
//   cnt_i shared frame counter; pwm_o pulse output.
module servo_pwm_channel
  import servo_cmd_pkg::*;
#(
  parameter int CW = 21,
  parameter int MIN_TICKS = 50000,
  parameter int STEP_TICKS = 394
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [POS_W-1:0] pos_i,
  input  logic             en_i,
  input  logic [CW-1:0]    cnt_i,
  output logic             pwm_o
);
  logic [POS_W-1:0] pos_q;
  logic en_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q <= POS_CENTER;
      en_q <= 1'b0;
    end else if (load_i) begin
      pos_q <= pos_i;
      en_q <= en_i;
    end
  end
  assign pwm_o = en_q && (cnt_i < CW'(MIN_TICKS) + CW'(pos_q) * CW'(STEP_TICKS));
endmodule

// File: rtl/servo_command_exec.sv
// servo_command_exec: executes assembled servo instructions and drives one PWM output per channel
// Ports: clk, rst_n (sync, active low); instruction/full from the serial assembler (full is async);
//   pwm_out per channel; cmd_done/cmd_err one-cycle status pulses; busy while an instruction
//   is in flight; frame_sync one-cycle pulse at the start of each PWM frame.
// Build option: define WATCHDOG_EN to clear the enable mask (and pulse cmd_err once) after
//   TIMEOUT_FRAMES frames without a legal instruction.
module servo_command_exec
  import servo_cmd_pkg::*;
#(
  parameter int NUM_SERVOS = 4,
  parameter int PERIOD_TICKS = 1000000,
  parameter int MIN_TICKS = 50000,
  parameter int STEP_TICKS = 394
`ifdef WATCHDOG_EN
  ,
  parameter int TIMEOUT_FRAMES = 50
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INSTR_W-1:0]    instruction,
  input  logic                  full,
  output logic [NUM_SERVOS-1:0] pwm_out,
  output logic                  cmd_done,
  output logic                  cmd_err,
  output logic                  busy,
  output logic                  frame_sync
);
  localparam int CW = $clog2(PERIOD_TICKS) + 1;
  state_e state_q, state_d;
  logic [2:0] sync_q;
  logic [1:0] vld_q;
  logic armed_q, evt, capture, drop, exec, legal, wr, wd_fire;
  logic done_q, err_q, fin_q;
  logic [INSTR_W-1:0] instr_q;
  logic [1:0] op, id;
  logic [POS_W-1:0] val;
  logic [POS_W-1:0] pos_q [MAX_SERVOS];
  logic [POS_W-1:0] pos_d [MAX_SERVOS];
  logic [NUM_SERVOS-1:0] en_q, en_d;
  logic [CW-1:0] cnt_q;

  assign op = instr_q[OP_HI:OP_LO];
  assign id = instr_q[ID_HI:ID_LO];
  assign val = instr_q[VAL_HI:VAL_LO];
  // sync_q[1] is the synchronised level, sync_q[2] its delayed copy. armed_q only rises once a
  // genuine post-reset sample of full is low, so a level held across reset cannot re-trigger.
  assign evt = sync_q[1] & ~sync_q[2] & armed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = capture ? EXEC : IDLE;
  end

  always_comb begin
    exec = state_q == EXEC;
    busy = exec | fin_q;
    capture = evt & ~busy;
    drop = evt & busy;
    cmd_done = done_q;
    cmd_err = err_q;
    frame_sync = rst_n & (cnt_q == '0);
  end

  always_comb begin
    legal = (op == OP_SYS) ? (val < 7'd2) : (op == OP_MASK) || (int'(id) < NUM_SERVOS);
    wr = exec & legal;
    pos_d = pos_q;
    en_d = en_q;
    if (wr && op == OP_SET) pos_d[id] = val;
    if (wr && op == OP_STEP) pos_d[id] = sat_step(pos_q[id], val);
    if (wr && op == OP_MASK) en_d = val[NUM_SERVOS-1:0];
    if (wr && op == OP_SYS) pos_d = '{default: POS_CENTER};
    if (wr && op == OP_SYS && val[0]) en_d = '0;
    if (wd_fire) en_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      vld_q <= '0;
      armed_q <= 1'b0;
      instr_q <= '0;
      pos_q <= '{default: POS_CENTER};
      en_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], full};
      vld_q <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ~sync_q[1]);
      if (capture) instr_q <= instruction;
      pos_q <= pos_d;
      en_q <= en_d;
      cnt_q <= (cnt_q == CW'(PERIOD_TICKS - 1)) ? '0 : cnt_q + 1'b1;
      done_q <= wr;
      err_q <= (exec & ~legal) | drop | wd_fire;
      fin_q <= exec;
    end
  end

`ifdef WATCHDOG_EN
  logic [$clog2(TIMEOUT_FRAMES + 1)-1:0] wd_q;
  always_ff @(posedge clk) begin
    if (!rst_n) wd_q <= '0;
    else if (wr) wd_q <= '0;
    else if (frame_sync && int'(wd_q) < TIMEOUT_FRAMES) wd_q <= wd_q + 1'b1;
  end
  assign wd_fire = frame_sync & ~wr & (int'(wd_q) == TIMEOUT_FRAMES - 1);
`else
  assign wd_fire = 1'b0;
`endif

  // Shadows load at counter 0 from pos_q/en_q, i.e. the values before any same-cycle write
  for (genvar i = 0; i < NUM_SERVOS; i++) begin : g_ch
    servo_pwm_channel #(
      .CW(CW),
      .MIN_TICKS(MIN_TICKS),
      .STEP_TICKS(STEP_TICKS)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .load_i(frame_sync),
      .pos_i(pos_q[i]),
      .en_i(en_q[i]),
      .cnt_i(cnt_q),
      .pwm_o(pwm_out[i])
    );
  end
endmodule
